taiga_axil_master: RTL

Parametrised AXI4-Lite master bridge between the Taiga core's peripheral bus request/response stream and the system AXI4-Lite interconnect. It generalises the fixed 32-bit, single-outstanding, combinational bus hookup to configurable address and data widths. It supports up to MAX_OUTSTANDING in-flight transactions of one direction, in-order tagged responses, independent AW/W issue, response back-pressure and a sticky bus-timeout monitor. It sits at the top level between the core's bus port and the interconnect.

---
 rtl/taiga_bus_pkg.sv | 34 +++
 rtl/taiga_tag_fifo.sv | 52 +++++
 rtl/taiga_axil_master.sv | 138 +++++++++++++
 3 files changed

// File: rtl/taiga_bus_pkg.sv
// taiga_bus_pkg: shared AXI4-Lite response codes and default-width bus request/response records
package taiga_bus_pkg;

   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;
   localparam int BUS_ID_W   = 4;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } axil_resp_t;

   typedef struct packed {
      logic                    wr;
      logic [BUS_ADDR_W-1:0]   addr;
      logic [BUS_DATA_W-1:0]   wdata;
      logic [BUS_DATA_W/8-1:0] be;
      logic [BUS_ID_W-1:0]     id;
   } bus_req_t;

   typedef struct packed {
      logic [BUS_DATA_W-1:0] rdata;
      logic                  err;
      logic [BUS_ID_W-1:0]   id;
   } bus_rsp_t;

   // SLVERR and DECERR both report as a failed access to the core
   function automatic logic resp_is_err(input logic [1:0] r);
      return (r == SLVERR) || (r == DECERR);
   endfunction

endpackage

// File: rtl/taiga_tag_fifo.sv
// taiga_tag_fifo: in-order request tag queue with wrapping pointers and an occupancy count
module taiga_tag_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, rptr_q;
   logic [PW:0]      cnt_q;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign data_o = mem_q[rptr_q];

   // tag storage needs no reset; only occupied entries are ever read
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wptr_q] <= data_i;
   end

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_i) wptr_q <= wrap_inc(wptr_q);
         if (pop_i) rptr_q <= wrap_inc(rptr_q);
         cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
      end
   end

   // overflow and underflow are upstream bugs
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(push_i && cnt_q == (PW+1)'(DEPTH)));
         assert (!(pop_i && cnt_q == '0));
      end
   end

endmodule

// File: rtl/taiga_axil_master.sv
// taiga_axil_master: Taiga peripheral request/response stream to AXI4-Lite master bridge
module taiga_axil_master
   import taiga_bus_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int ID_W            = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic                               req_wr,
   input  logic [ADDR_W-1:0]                  req_addr,
   input  logic [DATA_W-1:0]                  req_wdata,
   input  logic [DATA_W/8-1:0]                req_be,
   input  logic [ID_W-1:0]                    req_id,
   output logic                               rsp_valid,
   input  logic                               rsp_ready,
   output logic [DATA_W-1:0]                  rsp_rdata,
   output logic                               rsp_err,
   output logic [ID_W-1:0]                    rsp_id,
   output logic [ADDR_W-1:0]                  m_axi_araddr,
   output logic [2:0]                         m_axi_arprot,
   output logic                               m_axi_arvalid,
   input  logic                               m_axi_arready,
   input  logic [DATA_W-1:0]                  m_axi_rdata,
   input  logic [1:0]                         m_axi_rresp,
   input  logic                               m_axi_rvalid,
   output logic                               m_axi_rready,
   output logic [ADDR_W-1:0]                  m_axi_awaddr,
   output logic [2:0]                         m_axi_awprot,
   output logic                               m_axi_awvalid,
   input  logic                               m_axi_awready,
   output logic [DATA_W-1:0]                  m_axi_wdata,
   output logic [DATA_W/8-1:0]                m_axi_wstrb,
   output logic                               m_axi_wvalid,
   input  logic                               m_axi_wready,
   input  logic [1:0]                         m_axi_bresp,
   input  logic                               m_axi_bvalid,
   output logic                               m_axi_bready,
   output logic                               bus_timeout,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   logic [CNT_W-1:0] count_q, count_d;
   logic             dir_q;
   logic             accept, r_hs, b_hs, done, rsp_free, dir_ok, slot_ok;
   logic [ID_W-1:0]  head_id;

   assign m_axi_arprot = 3'b000;
   assign m_axi_awprot = 3'b000;
   assign outstanding  = count_q;

   // a channel slot counts as free when it is empty or handing off this cycle, giving 1 req/cycle
   assign dir_ok   = (count_q == '0) || (dir_q == req_wr);
   assign slot_ok  = req_wr ? ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready))
                            : (!m_axi_arvalid || m_axi_arready);
   assign req_ready = rst_n && (count_q < CNT_W'(MAX_OUTSTANDING)) && dir_ok && slot_ok;
   assign accept   = req_valid && req_ready;
   assign rsp_free = !rsp_valid || rsp_ready;
   assign m_axi_rready = rsp_free;
   assign m_axi_bready = rsp_free;
   assign r_hs     = m_axi_rvalid && rsp_free;
   assign b_hs     = m_axi_bvalid && rsp_free && !m_axi_rvalid;
   assign done     = r_hs || b_hs;
   assign count_d  = count_q + CNT_W'(accept) - CNT_W'(done);

   taiga_tag_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(ID_W)) u_tags (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (accept),
      .pop_i  (done),
      .data_i (req_id),
      .data_o (head_id)
   );

   // channel output registers, direction tracking and the one-entry response register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q       <= '0;
         dir_q         <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_err       <= 1'b0;
         rsp_id        <= '0;
      end else begin
         count_q <= count_d;
         if (accept) dir_q <= req_wr;
         m_axi_arvalid <= (accept && !req_wr) ? 1'b1 : (m_axi_arvalid && !m_axi_arready);
         m_axi_awvalid <= (accept && req_wr) ? 1'b1 : (m_axi_awvalid && !m_axi_awready);
         m_axi_wvalid  <= (accept && req_wr) ? 1'b1 : (m_axi_wvalid && !m_axi_wready);
         if (accept && !req_wr) m_axi_araddr <= req_addr;
         if (accept && req_wr) begin
            m_axi_awaddr <= req_addr;
            m_axi_wdata  <= req_wdata;
            m_axi_wstrb  <= req_be;
         end
         rsp_valid <= done || (rsp_valid && !rsp_ready);
         if (done) begin
            rsp_rdata <= r_hs ? m_axi_rdata : '0;
            rsp_err   <= resp_is_err(r_hs ? m_axi_rresp : m_axi_bresp);
            rsp_id    <= head_id;
         end
      end
   end

   if (TIMEOUT_CYCLES > 0) begin : g_tmo
      localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
      logic [TW-1:0] tmo_q;
      // count idle cycles while work is pending; the flag is sticky until reset
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            tmo_q       <= '0;
            bus_timeout <= 1'b0;
         end else if (done || count_q == '0) begin
            tmo_q <= '0;
         end else if (tmo_q != TW'(TIMEOUT_CYCLES)) begin
            tmo_q <= tmo_q + 1'b1;
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) bus_timeout <= 1'b1;
         end
      end
   end else begin : g_no_tmo
      assign bus_timeout = 1'b0;
   end

endmodule
